// File: rtl/host_cycle_sync_pkg.sv
// Shared definitions for the host bus-cycle controller: state encoding and
// default host-cycle counts for normal (2MHz) and stretched (1MHz) accesses.
package host_cycle_sync_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NORM_CYCLES_DEF = 1;
  localparam int FE4X_CYCLES_DEF = 2;

  // Larger of the two cycle counts; the host-cycle counter must hold it.
  function automatic int max_cycles(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous host-clock input with
// single-clk rise/fall pulses derived from the synchronised level.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetb,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   q_d_p1;

  // Shift the async input through the chain; keep one extra delayed copy
  // of the synchronised level for edge detection.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sync_p0 <= '0;
      q_d_p1  <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], d};
      q_d_p1  <= sync_p0[SYNC_STAGES-1];
    end
  end

  assign q    = sync_p0[SYNC_STAGES-1];
  assign rise = ~q_d_p1 &  q;
  assign fall =  q_d_p1 & ~q;

endmodule

// File: rtl/host_cycle_sync.sv
// Host bus-cycle controller: holds the fast CPU while a host-bound access
// is aligned to the slow phi0, stretched for 1MHz regions, and completed.
module host_cycle_sync
  import host_cycle_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NORM_CYCLES = NORM_CYCLES_DEF,
  parameter int FE4X_CYCLES = FE4X_CYCLES_DEF,
  parameter int CNT_W       = 2
) (
  input  logic clk,
  input  logic resetb,
  input  logic bbc_phi0,
  input  logic host_req,
  input  logic cpu_rnw,
  input  logic dec_fe4x,
  output logic cpu_rdy,
  output logic lat_en,
  output logic bbc_rnw,
  output logic bbc_data_oe,
  output logic rdata_cap,
  output logic busy
);

  localparam logic [CNT_W-1:0] NORM_LOAD = CNT_W'(NORM_CYCLES);
  localparam logic [CNT_W-1:0] FE4X_LOAD = CNT_W'(FE4X_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             rnw_q;
  logic             fe_q;
  logic             phi0_s;
  logic             phi0_fall;
  logic             phi0_rise_unused;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_phi0_sync (
    .clk    (clk),
    .resetb (resetb),
    .d      (bbc_phi0),
    .q      (phi0_s),
    .rise   (phi0_rise_unused),
    .fall   (phi0_fall)
  );

  // Access sequencer: accept in IDLE, wait for a phi0 fall to start the
  // host cycle, count host periods, then release the CPU for one DONE clk.
  // A fall coincident with acceptance is never seen in ALIGN because the
  // fall pulse is only one clk wide.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state   <= IDLE;
      cnt     <= '0;
      rnw_q   <= 1'b1;
      fe_q    <= 1'b0;
      cpu_rdy <= 1'b1;
      lat_en  <= 1'b1;
      bbc_rnw <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (host_req) begin
            rnw_q   <= cpu_rnw;
            fe_q    <= dec_fe4x;
            cpu_rdy <= 1'b0;
            busy    <= 1'b1;
            state   <= ALIGN;
          end
        end
        ALIGN: begin
          if (phi0_fall) begin
            lat_en  <= 1'b0;
            bbc_rnw <= rnw_q;
            cnt     <= fe_q ? FE4X_LOAD : NORM_LOAD;
            state   <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (phi0_fall) begin
            if (cnt == CNT_LAST) begin
              cpu_rdy <= 1'b1;
              lat_en  <= 1'b1;
              bbc_rnw <= 1'b1;
              state   <= DONE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write data is driven only in the phi0-high half of each active host
  // period; read data is captured on the fall that ends the last period.
  assign bbc_data_oe = (state == ACTIVE) & ~rnw_q & phi0_s;
  assign rdata_cap   = (state == ACTIVE) &  rnw_q & phi0_fall & (cnt == CNT_LAST);

endmodule

// File: tb/tb_host_cycle_sync.sv
// Self-checking bench for host_cycle_sync: a fall-counting transaction
// model predicts every output each clk, plus directed literal checks.
`timescale 1ns/1ps
module tb_host_cycle_sync;

  localparam int SYNC_STAGES = 2;
  localparam int NORM_CYCLES = 1;
  localparam int FE4X_CYCLES = 2;
  localparam int CNT_W       = 2;

  logic clk      = 1'b0;
  logic resetb   = 1'b0;
  logic bbc_phi0 = 1'b0;
  logic host_req = 1'b0;
  logic cpu_rnw  = 1'b1;
  logic dec_fe4x = 1'b0;
  logic cpu_rdy, lat_en, bbc_rnw, bbc_data_oe, rdata_cap, busy;

  int n_cmp = 0;
  int n_bad = 0;

  // phi0 generator: toggles every 4 clk when running (8 clk period)
  bit phi_run = 1'b1;
  int phi_cnt = 0;

  // behavioural model: an access needs N+1 phi0 falls after acceptance
  logic [SYNC_STAGES:0] m_hist;
  bit m_xfer, m_done, m_rnw;
  int m_todo, m_n;

  // directed-check accumulators
  int cnt_lat_lo, cnt_rnw_lo, cnt_oe, cnt_cap, cnt_align, cnt_rdy0, cnt_done;

  host_cycle_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .NORM_CYCLES(NORM_CYCLES),
    .FE4X_CYCLES(FE4X_CYCLES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .resetb     (resetb),
    .bbc_phi0   (bbc_phi0),
    .host_req   (host_req),
    .cpu_rnw    (cpu_rnw),
    .dec_fe4x   (dec_fe4x),
    .cpu_rdy    (cpu_rdy),
    .lat_en     (lat_en),
    .bbc_rnw    (bbc_rnw),
    .bbc_data_oe(bbc_data_oe),
    .rdata_cap  (rdata_cap),
    .busy       (busy)
  );

  always #31.25 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic bit m_phi_s();
    return m_hist[SYNC_STAGES-1];
  endfunction

  function automatic bit m_fall();
    return m_hist[SYNC_STAGES] & ~m_hist[SYNC_STAGES-1];
  endfunction

  task automatic m_reset();
    m_hist = '0;
    m_xfer = 1'b0;
    m_done = 1'b0;
    m_rnw  = 1'b1;
    m_todo = 0;
    m_n    = 0;
  endtask

  task automatic m_clock();
    bit f;
    if (!resetb) begin
      m_reset();
      return;
    end
    f = m_fall();
    if (m_done) begin
      m_done = 1'b0;
    end else if (!m_xfer) begin
      if (host_req) begin
        m_xfer = 1'b1;
        m_rnw  = cpu_rnw;
        m_n    = dec_fe4x ? FE4X_CYCLES : NORM_CYCLES;
        m_todo = m_n + 1;
      end
    end else if (f) begin
      m_todo--;
      if (m_todo == 0) begin
        m_xfer = 1'b0;
        m_done = 1'b1;
      end
    end
    m_hist = {m_hist[SYNC_STAGES-1:0], bbc_phi0};
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b required %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clr_counts();
    cnt_lat_lo = 0; cnt_rnw_lo = 0; cnt_oe = 0; cnt_cap = 0;
    cnt_align = 0; cnt_rdy0 = 0; cnt_done = 0;
  endtask

  task automatic compare_all();
    bit started;
    started = m_xfer && (m_todo <= m_n);
    chk("cpu_rdy",     cpu_rdy,     !m_xfer);
    chk("lat_en",      lat_en,      !started);
    chk("bbc_rnw",     bbc_rnw,     started ? m_rnw : 1'b1);
    chk("busy",        busy,        m_xfer | m_done);
    chk("bbc_data_oe", bbc_data_oe, started & !m_rnw & m_phi_s());
    chk("rdata_cap",   rdata_cap,   started & m_rnw & (m_todo == 1) & m_fall());
    chk("oe_cap_excl", bbc_data_oe & rdata_cap, 1'b0);
    if (!lat_en)                     cnt_lat_lo++;
    if (!bbc_rnw)                    cnt_rnw_lo++;
    if (bbc_data_oe)                 cnt_oe++;
    if (rdata_cap)                   cnt_cap++;
    if (busy && lat_en && !cpu_rdy)  cnt_align++;
    if (!cpu_rdy)                    cnt_rdy0++;
    if (busy && cpu_rdy)             cnt_done++;
  endtask

  task automatic tick();
    @(posedge clk);
    m_clock();
    @(negedge clk);
    if (phi_run) begin
      phi_cnt++;
      if (phi_cnt == 4) begin
        phi_cnt  = 0;
        bbc_phi0 = ~bbc_phi0;
      end
    end
    compare_all();
  endtask

  task automatic wait_rdy(input int budget, input string tag);
    for (int i = 0; i < budget && !cpu_rdy; i++) tick();
    chk(tag, cpu_rdy, 1'b1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) tick();
    chk("idle_reached", busy, 1'b0);
  endtask

  // one access; inputs flip after acceptance to show they are captured
  task automatic do_access(input bit rnw, input bit fe);
    wait_idle();
    clr_counts();
    cpu_rnw  = rnw;
    dec_fe4x = fe;
    host_req = 1'b1;
    tick();
    chk("rdy_low_after_req", cpu_rdy, 1'b0);
    host_req = 1'b0;
    cpu_rnw  = ~rnw;
    dec_fe4x = ~fe;
    wait_rdy(200, "access_done");
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cpu_rdy"}, cpu_rdy,     1'b1);
    chk({tag, "_lat_en"},  lat_en,      1'b1);
    chk({tag, "_bbc_rnw"}, bbc_rnw,     1'b1);
    chk({tag, "_oe"},      bbc_data_oe, 1'b0);
    chk({tag, "_cap"},     rdata_cap,   1'b0);
    chk({tag, "_busy"},    busy,        1'b0);
  endtask

  initial begin
    m_reset();
    clr_counts();
    @(negedge clk);
    chk_reset_vals("reset");
    tick();
    resetb = 1'b1;
    repeat (6) tick();

    // normal read: lat_en low for one host period, a single capture pulse
    do_access(1'b1, 1'b0);
    chk_int("norm_lat_lo_clks", cnt_lat_lo, 8);
    chk_int("norm_cap_pulses",  cnt_cap,    1);
    chk_int("norm_oe_clks",     cnt_oe,     0);

    // FE4x write: two host periods, data driven in the phi0-high halves
    do_access(1'b0, 1'b1);
    chk_int("fe_rnw_lo_clks", cnt_rnw_lo, 16);
    chk_int("fe_oe_clks",     cnt_oe,     8);
    chk_int("fe_cap_pulses",  cnt_cap,    0);
    chk_int("fe_lat_lo_clks", cnt_lat_lo, 16);

    // request on the same clk as a fall: that fall must be skipped
    wait_idle();
    for (int i = 0; i < 20 && !m_fall(); i++) tick();
    chk("coinc_fall_found", m_fall(), 1'b1);
    clr_counts();
    cpu_rnw  = 1'b1;
    dec_fe4x = 1'b0;
    host_req = 1'b1;
    tick();
    host_req = 1'b0;
    wait_rdy(200, "coinc_done");
    chk_int("coinc_align_clks", cnt_align, 8);
    chk_int("coinc_cap_pulses", cnt_cap,   1);

    // back-to-back reads with host_req held high
    wait_idle();
    clr_counts();
    cpu_rnw  = 1'b1;
    dec_fe4x = 1'b0;
    host_req = 1'b1;
    for (int i = 0; i < 200 && cnt_done < 3; i++) tick();
    chk_int("b2b_done_clks",   cnt_done, 3);
    chk_int("b2b_cap_pulses",  cnt_cap,  3);
    host_req = 1'b0;

    // reset pulse during an active write
    wait_idle();
    cpu_rnw  = 1'b0;
    dec_fe4x = 1'b1;
    host_req = 1'b1;
    tick();
    host_req = 1'b0;
    for (int i = 0; i < 50 && lat_en; i++) tick();
    chk("rst_reached_active", lat_en, 1'b0);
    repeat (5) tick();
    resetb = 1'b0;
    #1;
    chk_reset_vals("midrst");
    tick();
    resetb = 1'b1;
    tick();
    do_access(1'b1, 1'b0);
    chk_int("postrst_lat_lo_clks", cnt_lat_lo, 8);
    chk_int("postrst_cap_pulses",  cnt_cap,    1);

    // phi0 stopped while aligning: CPU held indefinitely, then completes
    wait_idle();
    phi_run  = 1'b0;
    cpu_rnw  = 1'b1;
    dec_fe4x = 1'b0;
    host_req = 1'b1;
    tick();
    host_req = 1'b0;
    clr_counts();
    repeat (1000) tick();
    chk_int("stall_rdy_low_clks", cnt_rdy0, 1000);
    phi_run = 1'b1;
    clr_counts();
    wait_rdy(200, "stall_done");
    chk_int("stall_cap_pulses", cnt_cap, 1);

    // randomized traffic with phi0 stalls and occasional resets
    for (int i = 0; i < 4000; i++) begin
      host_req = ($urandom_range(0, 3) != 0);
      cpu_rnw  = $urandom_range(0, 1);
      dec_fe4x = $urandom_range(0, 1);
      if (phi_run) begin
        if ($urandom_range(0, 199) == 0) phi_run = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        phi_run = 1'b1;
      end
      if ($urandom_range(0, 499) == 0) begin
        resetb = 1'b0;
        tick();
        resetb = 1'b1;
      end
      tick();
    end
    host_req = 1'b0;
    phi_run  = 1'b1;
    repeat (40) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/host_cycle_sync.md
Name: host_cycle_sync

Overview:
- Bus-cycle controller downstream of the address decoder/latch stage.
- Takes a host-bound CPU access (host_req plus dec_fe4x from the decoder), holds the fast CPU with cpu_rdy, and aligns the access to the slow host bus phi0.
- Drives lat_en for the transparent bbc_adr latch, host bus direction and data-capture strobes.
- Stretches FE4x/FC/FD (1MHz) accesses over extra host cycles.

Parameters:
- SYNC_STAGES, 2, number of flops synchronising bbc_phi0 into clk domain (min 2).
- NORM_CYCLES, 1, host phi0 cycles occupied by a normal 2MHz host access.
- FE4X_CYCLES, 2, host phi0 cycles occupied when dec_fe4x is set.
- CNT_W, 2, width of host-cycle counter; must hold max(NORM_CYCLES, FE4X_CYCLES).

Ports:
- clk, input, 1, fast system clock; all state on rising edge.
- resetb, input, 1, asynchronous active-low reset.
- bbc_phi0, input, 1, host 2MHz phi0, asynchronous to clk.
- host_req, input, 1, level: current CPU cycle targets the host bus; sampled only in IDLE.
- cpu_rnw, input, 1, CPU read/not-write; captured at acceptance.
- dec_fe4x, input, 1, decoder flag: 1MHz stretched access; captured at acceptance.
- cpu_rdy, output, 1, 1 = CPU may proceed, 0 = CPU held.
- lat_en, output, 1, address latch transparent when 1, holding when 0.
- bbc_rnw, output, 1, host bus R/nW.
- bbc_data_oe, output, 1, drive CPU write data onto host data bus.
- rdata_cap, output, 1, one-clk pulse: capture host read data.
- busy, output, 1, 1 in any state other than IDLE.

Behaviour:
- Reset values (async, while resetb=0):
  - State: IDLE.
  - cpu_rdy=1, lat_en=1, bbc_rnw=1, bbc_data_oe=0, rdata_cap=0, busy=0.
  - Counter 0; sync chain cleared to 0.
- Synchroniser and edge detect:
  - phi0_s is the last flop of the SYNC_STAGES chain; phi0_d is phi0_s delayed one clk.
  - fall = phi0_d & ~phi0_s; rise = ~phi0_d & phi0_s.
- States: IDLE, ALIGN, ACTIVE, DONE.
- IDLE:
  - cpu_rdy=1, lat_en=1, bbc_rnw=1, bbc_data_oe=0.
  - If host_req=1: capture rnw_q<=cpu_rnw and fe_q<=dec_fe4x, drive cpu_rdy=0 from the next clk, go to ALIGN.
- ALIGN:
  - cpu_rdy=0, lat_en=1 (address still tracking).
  - On fall: lat_en=0 from the next clk, load cnt with FE4X_CYCLES if fe_q else NORM_CYCLES, go to ACTIVE.
  - A fall coincident with entry into ALIGN is not used; ALIGN always waits for a fall seen while in ALIGN.
- ACTIVE:
  - cpu_rdy=0, lat_en=0, bbc_rnw=rnw_q.
  - bbc_data_oe = ~rnw_q & phi0_s.
  - On fall with cnt==1: go to DONE; if rnw_q=1, pulse rdata_cap for that same clk.
  - On fall with cnt>1: decrement cnt and stay in ACTIVE.
- DONE (exactly 1 clk):
  - cpu_rdy=1, lat_en=1, bbc_rnw=1, bbc_data_oe=0; go to IDLE.
  - host_req is ignored in DONE. A new request is accepted in IDLE on the following clk.
- Latency, from the fall that starts the host cycle to cpu_rdy=1: N host phi0 periods + 1 clk, where N = NORM_CYCLES or FE4X_CYCLES.
- host_req deasserting during ALIGN or ACTIVE has no effect; the access runs to completion.
- dec_fe4x or cpu_rnw changing after acceptance has no effect, because captured values are used.
- bbc_phi0 stopping leaves the block in ALIGN/ACTIVE indefinitely with cpu_rdy=0. There is no timeout.
- Reset asserted mid-access immediately forces all reset values. No pending strobe survives reset.
- rdata_cap and bbc_data_oe are never 1 in the same clk.

Decomposition:
- Shared package holds:
  - State encoding constants (IDLE=2'd0, ALIGN=2'd1, ACTIVE=2'd2, DONE=2'd3).
  - Default cycle counts NORM_CYCLES/FE4X_CYCLES.
- One sub-module: sync_edge_det (parameter SYNC_STAGES; ports clk, resetb, d → q, rise, fall). It is reused for other host-clock inputs.

Test Plan:
- Common bench setup: clk 16MHz, bbc_phi0 2MHz at 50% duty (8 clk period), cpu_rnw=1.
- Normal read: host_req=1, dec_fe4x=0 → cpu_rdy=0 next clk; lat_en falls 1 clk after the first in-ALIGN fall; exactly one rdata_cap pulse at the next fall; cpu_rdy=1 one clk later (8 clk after lat_en fell).
- FE4x write (cpu_rnw=0, dec_fe4x=1, FE4X_CYCLES=2) → bbc_rnw=0 for 16 clk; bbc_data_oe high only while phi0_s=1 (two 4-clk windows); no rdata_cap; cpu_rdy returns after the second fall.
- Request on same clk as a fall → that fall ignored; host cycle starts at the following fall (8 clk later).
- Back-to-back requests (host_req held high) → DONE lasts 1 clk with cpu_rdy=1; second access enters ALIGN on the IDLE clk after DONE; no lost or duplicate rdata_cap.
- resetb low for 1 clk during ACTIVE → cpu_rdy=1, lat_en=1, bbc_rnw=1, bbc_data_oe=0 immediately; a subsequent host_req starts cleanly from IDLE.
- Stopped phi0 during ALIGN → cpu_rdy stays 0 for 1000 clk; restarting phi0 completes the access normally.
